// File: rtl/rect_fill.sv
// Fills the whole frame or a clipped rectangle with one colour, one pixel per
// un-held cycle in raster order, driving a VGA adapter pixel-write port.
module rect_fill #(
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120,
  parameter int unsigned X_WIDTH      = 8,
  parameter int unsigned Y_WIDTH      = 7,
  parameter int unsigned COLOUR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [X_WIDTH-1:0]      rect_x,
  input  logic [Y_WIDTH-1:0]      rect_y,
  input  logic [X_WIDTH:0]        rect_w,
  input  logic [Y_WIDTH:0]        rect_h,
  input  logic [COLOUR_WIDTH-1:0] fill_colour,
  input  logic                    hold,
  output logic [X_WIDTH-1:0]      x,
  output logic [Y_WIDTH-1:0]      y,
  output logic [COLOUR_WIDTH-1:0] colour,
  output logic                    plot,
  output logic                    busy,
  output logic                    done
);

  localparam logic [X_WIDTH:0] ScreenW = (X_WIDTH+1)'(SCREEN_W);
  localparam logic [Y_WIDTH:0] ScreenH = (Y_WIDTH+1)'(SCREEN_H);

  typedef enum logic [1:0] {StIdle, StFill, StFinish} state_e;

  state_e                  state_q, state_d;
  logic [X_WIDTH-1:0]      x_q, x_d, cx_q, cx_d, x0_q, x0_d, xl_q, xl_d;
  logic [Y_WIDTH-1:0]      y_q, y_d, cy_q, cy_d, yl_q, yl_d;
  logic [COLOUR_WIDTH-1:0] colour_q, colour_d, fc_q, fc_d;
  logic                    plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  // Effective region derived from the live inputs; only used on the start edge.
  logic [X_WIDTH:0]   avail_w, eff_w, x_end;
  logic [Y_WIDTH:0]   avail_h, eff_h, y_end;
  logic [X_WIDTH-1:0] org_x;
  logic [Y_WIDTH-1:0] org_y;
  logic               empty;

  always_comb begin
    avail_w = ScreenW - {1'b0, rect_x};
    avail_h = ScreenH - {1'b0, rect_y};
    eff_w   = (rect_w < avail_w) ? rect_w : avail_w;
    eff_h   = (rect_h < avail_h) ? rect_h : avail_h;
    if ({1'b0, rect_x} >= ScreenW) eff_w = '0;
    if ({1'b0, rect_y} >= ScreenH) eff_h = '0;
    org_x = rect_x;
    org_y = rect_y;
    if (!mode) begin
      eff_w = ScreenW;
      eff_h = ScreenH;
      org_x = '0;
      org_y = '0;
    end
    empty = (eff_w == '0) || (eff_h == '0);
    x_end = {1'b0, org_x} + eff_w - 1'b1;
    y_end = {1'b0, org_y} + eff_h - 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x0_d     = x0_q;
    xl_d     = xl_q;
    yl_d     = yl_q;
    fc_d     = fc_q;
    plot_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          fc_d    = fill_colour;
          x0_d    = org_x;
          cx_d    = org_x;
          cy_d    = org_y;
          xl_d    = x_end[X_WIDTH-1:0];
          yl_d    = y_end[Y_WIDTH-1:0];
          busy_d  = 1'b1;
          state_d = empty ? StFinish : StFill;
        end
      end
      StFill: begin
        if (!hold) begin
          x_d      = cx_q;
          y_d      = cy_q;
          colour_d = fc_q;
          plot_d   = 1'b1;
          if (cx_q == xl_q) begin
            cx_d = x0_q;
            if (cy_q == yl_q) state_d = StFinish;
            else cy_d = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x0_q     <= '0;
      xl_q     <= '0;
      yl_q     <= '0;
      fc_q     <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x0_q     <= x0_d;
      xl_q     <= xl_d;
      yl_q     <= yl_d;
      fc_q     <= fc_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rect_fill.sv
// Directed self-checking bench for rect_fill: full frame, rectangles, clipping,
// empty regions, hold stalls, ignored restarts and reset mid-fill.
module tb_rect_fill;

  logic       clk = 1'b0;
  logic       rst, start, mode, hold;
  logic [7:0] rect_x;
  logic [6:0] rect_y;
  logic [8:0] rect_w;
  logic [7:0] rect_h;
  logic [2:0] fill_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  rect_fill dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .rect_x     (rect_x),
    .rect_y     (rect_y),
    .rect_w     (rect_w),
    .rect_h     (rect_h),
    .fill_colour(fill_colour),
    .hold       (hold),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issue a start, then scramble the inputs to show they are latched.
  task automatic go(input bit m, input int rx, input int ry, input int rw, input int rh,
                    input int col);
    mode = m; rect_x = 8'(rx); rect_y = 7'(ry); rect_w = 9'(rw); rect_h = 8'(rh);
    fill_colour = 3'(col); hold = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; mode = ~m; rect_x = 8'd1; rect_y = 7'd2; rect_w = 9'd3; rect_h = 8'd1;
    fill_colour = ~3'(col);
  endtask

  // Follow a fill until done and compare against the expected raster sequence.
  task automatic watch(input string tag, input int x0, input int y0, input int w, input int h,
                       input int col, input bit poke);
    int n_plot = 0, bad = 0, last_plot = 0, done_at = -1, extra = 0;
    int busy_n = busy ? 1 : 0;
    for (int i = 1; i <= w * h + 20 && done_at < 0; i++) begin
      if (poke && i == 3) begin
        start = 1'b1; mode = 1'b1; rect_x = 8'd0; rect_y = 7'd0;
        rect_w = 9'd50; rect_h = 8'd50; fill_colour = 3'd7;
      end
      if (poke && i == 4) start = 1'b0;
      tick();
      if (busy) busy_n++;
      if (plot) begin
        if (n_plot >= w * h || int'(x) != x0 + n_plot % w || int'(y) != y0 + n_plot / w ||
            int'(colour) != col || !busy)
          bad++;
        n_plot++;
        last_plot = i;
      end
      if (done) done_at = i;
    end
    check({tag, "_plots"}, n_plot, w * h);
    check({tag, "_order_errs"}, bad, 0);
    check({tag, "_done_cycle"}, done_at, last_plot + 1);
    check({tag, "_busy_cycles"}, busy_n, w * h + 1);
    repeat (3) begin
      tick();
      if (plot || busy || done) extra++;
    end
    check({tag, "_idle_after"}, extra, 0);
  endtask

  int hold_t [8] = '{0, 1, 1, 1, 0, 1, 0, 0};
  int plot_t [8] = '{1, 0, 0, 0, 1, 0, 1, 0};
  int x_t    [8] = '{5, 5, 5, 5, 6, 6, 7, 7};
  int done_t [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    int seen;
    rst = 1'b0; start = 1'b0; mode = 1'b0; hold = 1'b0;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; fill_colour = 3'd5;
    tick();
    tick();
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b1;
    tick();

    go(1'b0, 0, 0, 0, 0, 0);
    watch("full", 0, 0, 160, 120, 0, 1'b0);

    go(1'b1, 10, 20, 4, 3, 4);
    watch("rect", 10, 20, 4, 3, 4, 1'b0);

    go(1'b1, 158, 118, 10, 10, 1);
    watch("clip", 158, 118, 2, 2, 1, 1'b0);

    go(1'b1, 160, 0, 5, 5, 2);
    watch("off_right", 160, 0, 0, 0, 2, 1'b0);

    go(1'b1, 30, 40, 0, 5, 2);
    watch("zero_w", 30, 40, 0, 5, 2, 1'b0);

    go(1'b1, 0, 0, 1, 1, 6);
    watch("single", 0, 0, 1, 1, 6, 1'b0);

    go(1'b1, 20, 30, 5, 2, 6);
    watch("restart", 20, 30, 5, 2, 6, 1'b1);

    // Hold stalls the sweep, including on the final pixel.
    go(1'b1, 5, 5, 3, 1, 2);
    for (int i = 0; i < 8; i++) begin
      hold = hold_t[i][0];
      tick();
      check($sformatf("hold_plot_%0d", i), int'(plot), plot_t[i]);
      check($sformatf("hold_x_%0d", i), int'(x), x_t[i]);
      check($sformatf("hold_y_%0d", i), int'(y), 5);
      check($sformatf("hold_done_%0d", i), int'(done), done_t[i]);
    end
    hold = 1'b0;

    // Reset after five pixels aborts without a done pulse.
    go(1'b1, 0, 0, 10, 10, 3);
    seen = 0;
    for (int i = 0; i < 20 && seen < 5; i++) begin
      tick();
      if (plot) seen++;
    end
    check("abort_plots", seen, 5);
    rst = 1'b0;
    tick();
    check("abort_outs", int'({x, y, colour, plot, busy, done}), 0);
    rst = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      if (done || plot || busy) seen++;
    end
    check("abort_quiet", seen, 0);
    go(1'b1, 3, 4, 2, 2, 5);
    watch("after_abort", 3, 4, 2, 2, 5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
